rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between NUM_REQ writeback requesters, e.g. ALU, load/store unit and mul/div unit.
- Arbitration is round-robin. The winning write is registered and driven onto the regfile we/waddr/wdata pins one cycle after grant.
- Sits between the execute/memory writeback sources and the register file.
- Publishes a pending-write view so the issue logic can detect hazards on in-flight writes.

Parameters:
- NUM_REQ, 3, number of writeback requesters, 2..8.
- AW, 5, register address width (RegNum = 2^AW).
- DW, 32, register data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- wb_stall  in  1  when high, no new grants are issued; the output stage keeps its current contents.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*AW  per-requester destination register, packed; requester i occupies bits [i*AW +: AW].
- req_data  in  NUM_REQ*DW  per-requester write data, packed the same way.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] && req_ready[i].
- rf_we  out  1  regfile write enable.
- rf_waddr  out  AW  regfile write address.
- rf_wdata  out  DW  regfile write data.
- pend_valid  out  1  the output stage holds a write not yet committed to the regfile.
- pend_addr  out  AW  address of that write.

Behaviour:
- Reset (rst high at posedge):
  - rf_we=0, rf_waddr=0, rf_wdata=0, pend_valid=0, pend_addr=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has top priority first.
  - req_ready=0 whenever rst is high; combinationally masked.
- Grant, combinational in cycle N:
  - If wb_stall=0 and any req_valid is set, grant the first valid index in the order last+1, last+2, ... (mod NUM_REQ).
  - Exactly one req_ready bit is high, otherwise all zero.
  - req_ready depends only on req_valid, last, wb_stall and rst, never on req_addr or req_data.
- Output stage, posedge ending cycle N:
  - Transfer from i: rf_waddr<=addr_i, rf_wdata<=data_i, last<=i.
  - rf_we<=1 if addr_i!=0. If addr_i==0 the request is consumed but rf_we<=0, so writes to $zero are dropped.
  - No transfer and wb_stall=0: rf_we<=0; rf_waddr and rf_wdata hold their values.
  - wb_stall=1: rf_we, rf_waddr and rf_wdata all hold. A pending write is re-presented, which is idempotent on the regfile.
- Latency:
  - Exactly 1 cycle from handshake to rf_we.
  - The regfile's write-through bypass makes the data readable in that same cycle.
- pend_valid=rf_we and pend_addr=rf_waddr, both registered copies.
- Fairness: a requester holding req_valid continuously is granted within NUM_REQ cycles of wb_stall=0.
- Ordering: no order is guaranteed between different requesters targeting the same register. Issue logic must not create that case.
- Requester rule: once req_valid is high, req_valid, req_addr and req_data stay stable until the handshake. The bench asserts this.
- Reset mid-operation: a write held in the output stage is discarded, because rf_we is 0 the cycle after reset. No partial state survives.
- last advances only on a transfer, never during stall or idle.

Decomposition:
- Shared package rf_pkg holds:
  - constants RegAddrW=5, RegW=32, RegNum=32, ZeroReg='0;
  - typedef rf_wr_t {logic we; logic [RegAddrW-1:0] addr; logic [RegW-1:0] data}, used for the output stage and pending view.
- One sub-module, rr_arbiter: parameterised NUM_REQ, purely combinational.
  - Inputs: request vector, last-grant index.
  - Outputs: one-hot grant and encoded index.
  - The pointer register stays in rf_wb_arbiter.

Test Plan:
- Reset: rst=1 for 2 cycles with all req_valid=1 -> req_ready=000, rf_we=0. First cycle after reset grants req0.
- Single requester: req1 writes r5=0xDEADBEEF in cycle N -> req_ready=010 in N; rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in N+1; rf_we=0 in N+2.
- Round-robin: req_valid=111 held with new data each grant -> grant sequence 0,1,2,0,1,2. No requester waits more than 3 cycles.
- Zero register: req2 writes r0=0x1234 -> handshake completes; rf_we=0, pend_valid=0 next cycle.
- Stall: req0 granted (r7=0x55) in N, wb_stall=1 for N+1..N+3 with req1 valid -> req_ready=000 during the stall. rf_we=1, rf_waddr=7 held throughout. req1 granted in the first cycle with wb_stall=0.
- Reset mid-write: req0 r3=0x99 handshakes in N, rst=1 in N+1 -> rf_we=0 in N+2, pend_valid=0, last=NUM_REQ-1.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file definitions: geometry constants and the write record
// carried by the writeback output stage.
package rf_pkg;

  localparam int RegAddrW = 5;
  localparam int RegW     = 32;
  localparam int RegNum   = 1 << RegAddrW;

  // Register 0 is hard-wired; writes to it are consumed but never committed.
  localparam logic [RegAddrW-1:0] ZeroReg = '0;

  // One register-file write as seen by the regfile port and the hazard view.
  typedef struct packed {
    logic                we;
    logic [RegAddrW-1:0] addr;
    logic [RegW-1:0]     data;
  } rf_wr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Searches the request vector starting one
// position after the last winner, wrapping modulo NUM_REQ, and returns the
// first hit as both a one-hot grant and an encoded index.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               grant_valid
);

  logic [IW-1:0] cand;

  // Walk the rotated priority order and latch onto the first requester found.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last) + k) % NUM_REQ);
      if (!grant_valid && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: shares the single register-file write port between
// NUM_REQ writeback sources. The winner is registered into an output stage
// that drives the regfile one cycle after the handshake and doubles as the
// pending-write view for hazard detection in issue.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int AW      = RegAddrW,
  parameter int DW      = RegW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_stall,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rf_we,
  output logic [AW-1:0]         rf_waddr,
  output logic [DW-1:0]         rf_wdata,
  output logic                  pend_valid,
  output logic [AW-1:0]         pend_addr
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req_eff;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               grant_valid;
  logic [IW-1:0]      last_q;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_data;
  rf_wr_t             out_q;

  // Stall and reset suppress every grant; only request valids reach the
  // arbiter, so the grant never depends on address or data.
  assign req_eff = (rst || wb_stall) ? '0 : req_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req         (req_eff),
    .last        (last_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign req_ready = grant;
  assign sel_addr  = req_addr[int'(grant_idx)*AW +: AW];
  assign sel_data  = req_data[int'(grant_idx)*DW +: DW];

  // Output stage and round-robin pointer: capture the winner, hold on stall,
  // drop the enable when idle, and clear everything on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      last_q <= IW'(NUM_REQ - 1);
    end else if (!wb_stall) begin
      if (grant_valid) begin
        out_q.we   <= (sel_addr != ZeroReg);
        out_q.addr <= sel_addr;
        out_q.data <= sel_data;
        last_q     <= grant_idx;
      end else begin
        out_q.we <= 1'b0;
      end
    end
  end

  assign rf_we      = out_q.we;
  assign rf_waddr   = out_q.addr;
  assign rf_wdata   = out_q.data;
  assign pend_valid = out_q.we;
  assign pend_addr  = out_q.addr;

endmodule
